alu_op_sequencer: RTL and testbench



---
 rtl/alu_ctrl_pkg.sv | 35 +++
 rtl/onehot_dec.sv | 12 +
 rtl/alu_op_sequencer.sv | 103 ++++++++++
 tb/tb_alu_op_sequencer.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: op-code classes and sequencer state encoding shared by the ALU control block.
package alu_ctrl_pkg;

    localparam int OP_W = 5;

    localparam logic [OP_W-1:0] OP_NOT = 5'b00100;
    localparam logic [OP_W-1:0] OP_NEG = 5'b00101;
    localparam logic [OP_W-1:0] OP_MUL = 5'b01111;
    localparam logic [OP_W-1:0] OP_DIV = 5'b10000;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD_Y = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_WB_LO  = 3'd3;
    localparam logic [2:0] ST_WB_HI  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        LOAD_Y = ST_LOAD_Y,
        EXEC   = ST_EXEC,
        WB_LO  = ST_WB_LO,
        WB_HI  = ST_WB_HI,
        DONE   = ST_DONE
    } state_t;

    function automatic logic is_unary(input logic [OP_W-1:0] op);
        return (op == OP_NOT) || (op == OP_NEG);
    endfunction

    function automatic logic is_wide(input logic [OP_W-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/onehot_dec.sv
// onehot_dec: 4-bit index to N-wide one-hot select, all zeros when disabled.
module onehot_dec #(
    parameter int N = 16
) (
    input  logic [3:0]   idx,
    input  logic         en,
    output logic [N-1:0] onehot
);

    assign onehot = en ? (N'(1) << idx) : '0;

endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: Moore FSM stepping the datapath strobes for one register-to-register ALU instruction.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int NREG = 16,
    parameter int OPW  = OP_W
) (
    input  logic            Clock,
    input  logic            clear,
    input  logic            start,
    input  logic [OPW-1:0]  opcode,
    input  logic [3:0]      ra,
    input  logic [3:0]      rb,
    input  logic [3:0]      rc,
    input  logic            hold,
    output logic            busy,
    output logic            done,
    output logic [OPW-1:0]  op,
    output logic [NREG-1:0] Rout,
    output logic [NREG-1:0] Rin,
    output logic            Yin,
    output logic            Zhighin,
    output logic            Zlowin,
    output logic            Zhighout,
    output logic            Zlowout,
    output logic            HIin,
    output logic            LOin
);

    state_t         state_q, state_d;
    logic [OPW-1:0] op_q, op_d;
    logic [3:0]     ra_q, ra_d, rb_q, rb_d, rc_q, rc_d;
    logic           unary, wide;

    assign unary = is_unary(OP_W'(op_q));
    assign wide  = is_wide(OP_W'(op_q));

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        rc_d    = rc_q;
        if (!hold) begin
            case (state_q)
                IDLE: if (start) begin
                    state_d = LOAD_Y;
                    op_d    = opcode;
                    ra_d    = ra;
                    rb_d    = rb;
                    rc_d    = rc;
                end
                LOAD_Y:  state_d = EXEC;
                EXEC:    state_d = WB_LO;
                WB_LO:   state_d = wide ? WB_HI : DONE;
                WB_HI:   state_d = DONE;
                DONE:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (clear) begin
            state_q <= IDLE;
            op_q    <= '0;
            ra_q    <= '0;
            rb_q    <= '0;
            rc_q    <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            rc_q    <= rc_d;
        end
    end

    // Outputs decode only registered state and latched fields, so hold freezes them for free.
    assign busy     = state_q != IDLE;
    assign done     = state_q == DONE;
    assign op       = busy ? op_q : '0;
    assign Yin      = state_q == LOAD_Y;
    assign Zlowin   = state_q == EXEC;
    assign Zhighin  = (state_q == EXEC) && wide;
    assign Zlowout  = state_q == WB_LO;
    assign LOin     = (state_q == WB_LO) && wide;
    assign Zhighout = state_q == WB_HI;
    assign HIin     = state_q == WB_HI;

    onehot_dec #(.N(NREG)) u_rout_dec (
        .idx    (state_q == LOAD_Y ? rb_q : rc_q),
        .en     ((state_q == LOAD_Y) || ((state_q == EXEC) && !unary)),
        .onehot (Rout)
    );

    onehot_dec #(.N(NREG)) u_rin_dec (
        .idx    (ra_q),
        .en     ((state_q == WB_LO) && !wide),
        .onehot (Rin)
    );

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer: directed per-scenario checks of the ALU op sequencer strobe timing.
module tb_alu_op_sequencer;

    logic        Clock, clear, start, hold;
    logic [4:0]  opcode, op;
    logic [3:0]  ra, rb, rc;
    logic        busy, done, Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin;
    logic [15:0] Rout, Rin;
    logic [45:0] obs;
    int          total = 0;
    int          bad = 0;

    alu_op_sequencer #(.NREG(16), .OPW(5)) dut (
        .Clock(Clock), .clear(clear), .start(start), .opcode(opcode),
        .ra(ra), .rb(rb), .rc(rc), .hold(hold),
        .busy(busy), .done(done), .op(op), .Rout(Rout), .Rin(Rin),
        .Yin(Yin), .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout),
        .Zlowout(Zlowout), .HIin(HIin), .LOin(LOin)
    );

    // {busy,done,Yin,Zhighin,Zlowin,Zhighout,Zlowout,HIin,LOin} | Rout | Rin | op
    assign obs = {busy, done, Yin, Zhighin, Zlowin, Zhighout, Zlowout, HIin, LOin, Rout, Rin, op};

    initial begin
        Clock = 0;
        forever #5 Clock = ~Clock;
    end

    task automatic issue(input logic [4:0] o, input logic [3:0] a, input logic [3:0] b, input logic [3:0] c);
        start = 1; opcode = o; ra = a; rb = b; rc = c;
        @(posedge Clock);
        #1 start = 0;
    endtask

    task automatic test_reset();
        clear = 1;
        repeat (2) @(negedge Clock);
        total++;
        if (obs !== 46'h0) begin bad++; $display("FAIL reset_held got=%h exp=%h", obs, 46'h0); end
        clear = 0;
        @(negedge Clock);
        total++;
        if (obs !== 46'h0) begin bad++; $display("FAIL reset_released got=%h exp=%h", obs, 46'h0); end
    endtask

    task automatic test_narrow();
        logic [45:0] e [5];
        e = '{{9'h140, 16'h0002, 16'h0000, 5'h03}, {9'h110, 16'h0004, 16'h0000, 5'h03},
              {9'h104, 16'h0000, 16'h0008, 5'h03}, {9'h180, 16'h0000, 16'h0000, 5'h03}, 46'h0};
        issue(5'h03, 4'd3, 4'd1, 4'd2);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            total++;
            if (obs !== e[i]) begin bad++; $display("FAIL narrow cyc+%0d got=%h exp=%h", i + 1, obs, e[i]); end
        end
    endtask

    task automatic test_unary();
        logic [45:0] e [5];
        e = '{{9'h140, 16'h0020, 16'h0000, 5'h04}, {9'h110, 16'h0000, 16'h0000, 5'h04},
              {9'h104, 16'h0000, 16'h0002, 5'h04}, {9'h180, 16'h0000, 16'h0000, 5'h04}, 46'h0};
        issue(5'h04, 4'd1, 4'd5, 4'd7);
        for (int i = 0; i < 5; i++) begin
            @(negedge Clock);
            total++;
            if (obs !== e[i]) begin bad++; $display("FAIL unary cyc+%0d got=%h exp=%h", i + 1, obs, e[i]); end
        end
    endtask

    task automatic test_wide();
        logic [45:0] e [6];
        e = '{{9'h140, 16'h0010, 16'h0000, 5'h0F}, {9'h130, 16'h0040, 16'h0000, 5'h0F},
              {9'h105, 16'h0000, 16'h0000, 5'h0F}, {9'h10A, 16'h0000, 16'h0000, 5'h0F},
              {9'h180, 16'h0000, 16'h0000, 5'h0F}, 46'h0};
        issue(5'h0F, 4'd2, 4'd4, 4'd6);
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            total++;
            if (obs !== e[i]) begin bad++; $display("FAIL wide cyc+%0d got=%h exp=%h", i + 1, obs, e[i]); end
        end
    endtask

    task automatic test_hold();
        logic [45:0] e [11];
        e = '{{9'h140, 16'h0001, 16'h0000, 5'h1F},
              {9'h110, 16'h8000, 16'h0000, 5'h1F}, {9'h110, 16'h8000, 16'h0000, 5'h1F},
              {9'h110, 16'h8000, 16'h0000, 5'h1F}, {9'h110, 16'h8000, 16'h0000, 5'h1F},
              {9'h104, 16'h0000, 16'h0001, 5'h1F},
              {9'h180, 16'h0000, 16'h0000, 5'h1F}, {9'h180, 16'h0000, 16'h0000, 5'h1F},
              {9'h180, 16'h0000, 16'h0000, 5'h1F}, 46'h0, 46'h0};
        issue(5'h1F, 4'd0, 4'd0, 4'd15);
        for (int i = 0; i < 11; i++) begin
            @(negedge Clock);
            total++;
            if (obs !== e[i]) begin bad++; $display("FAIL hold cyc+%0d got=%h exp=%h", i + 1, obs, e[i]); end
            // hold EXEC for 3 edges, pulse start while busy, then hold DONE for 2 edges
            if (i == 1) begin hold = 1; start = 1; opcode = 5'h0F; end
            if (i == 4) hold = 0;
            if (i == 6) hold = 1;
            if (i == 8) begin hold = 0; start = 0; end
        end
    endtask

    task automatic test_back_to_back();
        logic [45:0] e [11];
        logic [45:0] f [6];
        e = '{{9'h140, 16'h0010, 16'h0000, 5'h01}, {9'h110, 16'h0010, 16'h0000, 5'h01},
              {9'h104, 16'h0000, 16'h0010, 5'h01}, {9'h180, 16'h0000, 16'h0000, 5'h01}, 46'h0,
              {9'h140, 16'h0100, 16'h0000, 5'h10}, {9'h130, 16'h0200, 16'h0000, 5'h10},
              {9'h105, 16'h0000, 16'h0000, 5'h10}, {9'h10A, 16'h0000, 16'h0000, 5'h10},
              {9'h180, 16'h0000, 16'h0000, 5'h10}, 46'h0};
        f = '{46'h0, 46'h0, {9'h140, 16'h8000, 16'h0000, 5'h05}, {9'h110, 16'h0000, 16'h0000, 5'h05},
              {9'h104, 16'h0000, 16'h0001, 5'h05}, {9'h180, 16'h0000, 16'h0000, 5'h05}};
        issue(5'h01, 4'd4, 4'd4, 4'd4);
        for (int i = 0; i < 11; i++) begin
            @(negedge Clock);
            total++;
            if (obs !== e[i]) begin bad++; $display("FAIL b2b cyc+%0d got=%h exp=%h", i + 1, obs, e[i]); end
            if (i == 3) begin start = 1; opcode = 5'h10; ra = 4'd7; rb = 4'd8; rc = 4'd9; end
            if (i == 4) begin @(posedge Clock); #1 start = 0; end
        end
        hold = 1; start = 1; opcode = 5'h05; ra = 4'd0; rb = 4'd15; rc = 4'd3;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clock);
            total++;
            if (obs !== f[i]) begin bad++; $display("FAIL idle_hold cyc+%0d got=%h exp=%h", i + 1, obs, f[i]); end
            if (i == 1) begin hold = 0; @(posedge Clock); #1 start = 0; end
        end
        @(negedge Clock);
    endtask

    task automatic test_clear();
        logic [45:0] e [3];
        e = '{{9'h140, 16'h0400, 16'h0000, 5'h02}, {9'h110, 16'h0800, 16'h0000, 5'h02},
              {9'h104, 16'h0000, 16'h0200, 5'h02}};
        issue(5'h02, 4'd9, 4'd10, 4'd11);
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            total++;
            if (obs !== e[i]) begin bad++; $display("FAIL clear_pre cyc+%0d got=%h exp=%h", i + 1, obs, e[i]); end
        end
        clear = 1;
        @(negedge Clock);
        total++;
        if (obs !== 46'h0) begin bad++; $display("FAIL clear_abort got=%h exp=%h", obs, 46'h0); end
        clear = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clock);
            total++;
            if (obs !== 46'h0) begin bad++; $display("FAIL clear_after cyc+%0d got=%h exp=%h", i + 1, obs, 46'h0); end
        end
    endtask

    initial begin
        clear = 1; start = 0; hold = 0; opcode = 0; ra = 0; rb = 0; rc = 0;
        test_reset();
        test_narrow();
        test_unary();
        test_wide();
        test_hold();
        test_back_to_back();
        test_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
